// File: rtl/aemb_fsl_pkg.sv
// Shared constants and FSM encoding for the FSL bus responder.
package aemb_fsl_pkg;

  localparam int FSL_CHN       = 2;
  localparam int FSL_CHSEL_BIT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } fsl_state_t;

endpackage

// File: rtl/aemb_fsl_fifo.sv
// Synchronous FIFO, 2**AW entries, head visible combinationally.
// Push is refused when full and pop is refused when empty, both judged on the
// count at the start of the cycle, so a full FIFO popped this cycle only takes
// a new word next cycle.
module aemb_fsl_fifo #(
  parameter int DW = 32,
  parameter int AW = 2
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aemb_fsl_slv.sv
// Two-channel FSL responder: core PUT/GET on a Wishbone-classic port,
// accelerator valid/ready streams per channel. The bus ack is withheld until
// the addressed FIFO can complete the transfer.
//
//   state | meaning
//   IDLE  | wait for strobe; complete transfer when the addressed FIFO allows
//   ACK   | ack high for this one cycle; strobe ignored
module aemb_fsl_slv
  import aemb_fsl_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 2
) (
  input  logic                  gclk,
  input  logic                  grst_n,
  input  logic [14:2]           fsl_adr_i,
  input  logic                  fsl_stb_i,
  input  logic                  fsl_wre_i,
  input  logic [DW-1:0]         fsl_dat_i,
  output logic [DW-1:0]         fsl_dat_o,
  output logic                  fsl_ack_o,
  output logic [FSL_CHN*DW-1:0] put_dat_o,
  output logic [FSL_CHN-1:0]    put_vld_o,
  input  logic [FSL_CHN-1:0]    put_rdy_i,
  input  logic [FSL_CHN*DW-1:0] get_dat_i,
  input  logic [FSL_CHN-1:0]    get_vld_i,
  output logic [FSL_CHN-1:0]    get_rdy_o
);

  fsl_state_t state;
  fsl_state_t state_nxt;

  logic               chn;
  logic [11:0]        unused_adr;
  logic               xfer;
  logic [FSL_CHN-1:0] put_push;
  logic [FSL_CHN-1:0] put_pop;
  logic [FSL_CHN-1:0] put_full;
  logic [FSL_CHN-1:0] put_empty;
  logic [FSL_CHN-1:0] get_push;
  logic [FSL_CHN-1:0] get_pop;
  logic [FSL_CHN-1:0] get_full;
  logic [FSL_CHN-1:0] get_empty;
  logic [DW-1:0]      get_head [FSL_CHN];

  // Only the channel-select bit of the word address matters.
  assign chn        = fsl_adr_i[FSL_CHSEL_BIT];
  assign unused_adr = fsl_adr_i[14:3];

  for (genvar c = 0; c < FSL_CHN; c++) begin : gen_chn
    assign put_vld_o[c] = ~put_empty[c];
    assign put_pop[c]   = put_vld_o[c] & put_rdy_i[c];
    assign get_rdy_o[c] = ~get_full[c];
    assign get_push[c]  = get_vld_i[c] & get_rdy_o[c];

    aemb_fsl_fifo #(.DW(DW), .AW(AW)) u_put (
      .gclk   (gclk),
      .grst_n (grst_n),
      .push   (put_push[c]),
      .pop    (put_pop[c]),
      .din    (fsl_dat_i),
      .head   (put_dat_o[c*DW +: DW]),
      .full   (put_full[c]),
      .empty  (put_empty[c])
    );

    aemb_fsl_fifo #(.DW(DW), .AW(AW)) u_get (
      .gclk   (gclk),
      .grst_n (grst_n),
      .push   (get_push[c]),
      .pop    (get_pop[c]),
      .din    (get_dat_i[c*DW +: DW]),
      .head   (get_head[c]),
      .full   (get_full[c]),
      .empty  (get_empty[c])
    );
  end

  // Next state and FIFO strobes; a blocked transfer simply retries next cycle.
  always_comb begin
    state_nxt = state;
    put_push  = '0;
    get_pop   = '0;
    xfer      = 1'b0;
    if (state == IDLE) begin
      if (fsl_stb_i) begin
        if (fsl_wre_i) begin
          if (!put_full[chn]) begin
            put_push[chn] = 1'b1;
            xfer          = 1'b1;
          end
        end else if (!get_empty[chn]) begin
          get_pop[chn] = 1'b1;
          xfer         = 1'b1;
        end
      end
      if (xfer) begin
        state_nxt = ACK;
      end
    end else begin
      state_nxt = IDLE;
    end
  end

  // State register.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Registered bus outputs; read data holds until the next GET completes.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      fsl_ack_o <= 1'b0;
      fsl_dat_o <= '0;
    end else begin
      fsl_ack_o <= xfer;
      if (|get_pop) begin
        fsl_dat_o <= get_head[chn];
      end
    end
  end

endmodule

// File: tb/tb_aemb_fsl_slv.sv
// Scoreboard bench for aemb_fsl_slv: per-FIFO reference queues, expected
// transfers queued at issue time and consumed by a negedge monitor.
module tb_aemb_fsl_slv;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          gclk = 1'b0;
  logic          grst_n = 1'b0;
  logic [12:0]   fsl_adr_i;
  logic          fsl_stb_i;
  logic          fsl_wre_i;
  logic [DW-1:0] fsl_dat_i;
  logic [DW-1:0] fsl_dat_o;
  logic          fsl_ack_o;
  logic [2*DW-1:0] put_dat_o;
  logic [1:0]    put_vld_o;
  logic [1:0]    put_rdy_i;
  logic [2*DW-1:0] get_dat_i;
  logic [1:0]    get_vld_i;
  logic [1:0]    get_rdy_o;

  always #5 gclk = ~gclk;

  aemb_fsl_slv #(.DW(DW), .AW(2)) dut (
    .gclk      (gclk),
    .grst_n    (grst_n),
    .fsl_adr_i (fsl_adr_i),
    .fsl_stb_i (fsl_stb_i),
    .fsl_wre_i (fsl_wre_i),
    .fsl_dat_i (fsl_dat_i),
    .fsl_dat_o (fsl_dat_o),
    .fsl_ack_o (fsl_ack_o),
    .put_dat_o (put_dat_o),
    .put_vld_o (put_vld_o),
    .put_rdy_i (put_rdy_i),
    .get_dat_i (get_dat_i),
    .get_vld_i (get_vld_i),
    .get_rdy_o (get_rdy_o)
  );

  typedef struct packed {
    logic        wre;
    logic        ch;
    logic [31:0] dat;
  } xfer_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_ack_cyc = 0;

  xfer_t       exp_q [$];
  logic [31:0] put_q [2][$];
  logic [31:0] get_q [2][$];

  always @(posedge gclk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: consumes acks against the scoreboard, tracks accelerator traffic.
  always @(negedge gclk) begin
    xfer_t e;
    if (!grst_n) begin
      exp_q.delete();
      for (int c = 0; c < 2; c++) begin
        put_q[c].delete();
        get_q[c].delete();
      end
    end else begin
      if (fsl_ack_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.wre) begin
            put_q[e.ch].push_back(e.dat);
          end else if (get_q[e.ch].size() == 0) begin
            errors++;
            $display("FAIL get_no_data actual=ack expected=stall ch=%0d", e.ch);
          end else begin
            chk("get_data", fsl_dat_o, get_q[e.ch].pop_front());
          end
        end
      end
      for (int c = 0; c < 2; c++) begin
        chk("put_vld", put_vld_o[c], put_q[c].size() != 0);
        if (put_vld_o[c] && put_rdy_i[c] && put_q[c].size() != 0)
          chk("put_dat", put_dat_o[c*DW +: DW], put_q[c].pop_front());
        chk("get_rdy", get_rdy_o[c], get_q[c].size() != DEPTH);
        if (get_vld_i[c] && get_rdy_o[c] && get_q[c].size() < DEPTH)
          get_q[c].push_back(get_dat_i[c*DW +: DW]);
      end
    end
  end

  // Core-side transfer; called at posedge+1, returns at posedge+1 after ack.
  task automatic core_xfer(input logic wre, input logic ch, input logic [31:0] d,
                           input bit rst_on_ack, output int waited);
    logic [11:0] hi;
    bit got;
    hi = 12'($urandom_range(0, 4095));
    fsl_adr_i = {hi, ch};
    fsl_wre_i = wre;
    fsl_dat_i = d;
    fsl_stb_i = 1'b1;
    exp_q.push_back(xfer_t'{wre, ch, d});
    waited = 0;
    got = 1'b0;
    while (!got) begin
      @(negedge gclk);
      if (fsl_ack_o) begin
        got = 1'b1;
      end else begin
        waited++;
        if (waited > 300) begin
          errors++;
          $display("FAIL ack_timeout actual=%0d cycles expected<=300", waited);
          $display("CHECKS %0d ERRORS %0d", checks, errors);
          $fatal(1, "ack wait bound expired");
        end
      end
    end
    last_ack_cyc = cyc;
    if (rst_on_ack) begin
      #2;
      grst_n    = 1'b0;
      fsl_stb_i = 1'b0;
      #1;
      chk("rst_ack", fsl_ack_o, 0);
      chk("rst_dat", fsl_dat_o, 0);
      chk("rst_put_vld", put_vld_o, 0);
      chk("rst_get_rdy", get_rdy_o, 2'b11);
    end else begin
      @(posedge gclk);
      #1;
      fsl_stb_i = 1'b0;
    end
  endtask

  // Accelerator offers one GET word for one cycle.
  task automatic acc_get(input int ch, input logic [31:0] d, output int at_cyc);
    get_dat_i[ch*DW +: DW] = d;
    get_vld_i[ch] = 1'b1;
    at_cyc = cyc;
    @(posedge gclk);
    #1;
    get_vld_i[ch] = 1'b0;
  endtask

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, pc, rc;
    bit done;
    fsl_adr_i = '0; fsl_stb_i = 0; fsl_wre_i = 0; fsl_dat_i = '0;
    put_rdy_i = '0; get_dat_i = '0; get_vld_i = '0;
    repeat (3) @(posedge gclk);
    #1;
    chk("reset_ack", fsl_ack_o, 0);
    chk("reset_dat", fsl_dat_o, 0);
    chk("reset_put_vld", put_vld_o, 0);
    chk("reset_get_rdy", get_rdy_o, 2'b11);
    grst_n = 1'b1;
    @(posedge gclk); #1;

    // PUT ch0, minimum latency and single-cycle ack.
    core_xfer(1'b1, 1'b0, 32'hDEADBEEF, 0, w);
    chk("put_latency", w, 1);
    chk("ack_pulse", fsl_ack_o, 0);
    chk("put_vld_after", put_vld_o, 2'b01);
    chk("put_head", put_dat_o[31:0], 32'hDEADBEEF);

    // Accelerator word then GET ch1.
    acc_get(1, 32'h12345678, pc);
    core_xfer(1'b0, 1'b1, '0, 0, w);
    chk("get_latency", w, 1);
    chk("get_dat_ch1", fsl_dat_o, 32'h12345678);
    chk("get_rdy_ch1", get_rdy_o[1], 1);

    // Blocked GET ch0 satisfied by a late accelerator push.
    fork
      core_xfer(1'b0, 1'b0, '0, 0, w);
      begin
        repeat (5) @(posedge gclk);
        #1;
        acc_get(0, 32'hA5A5A5A5, pc);
      end
    join
    chk("get_block_delay", last_ack_cyc - pc, 2);
    chk("get_block_wait", w, 7);
    chk("get_dat_ch0", fsl_dat_o, 32'hA5A5A5A5);

    // Fill PUT ch1, fifth PUT stalls until one pop frees a slot.
    for (int v = 1; v <= 4; v++) begin
      core_xfer(1'b1, 1'b1, 32'(v), 0, w);
      chk("fill_latency", w, 1);
    end
    fork
      core_xfer(1'b1, 1'b1, 32'd5, 0, w);
      begin
        repeat (3) @(posedge gclk);
        #1;
        put_rdy_i[1] = 1'b1;
        rc = cyc;
        @(posedge gclk); #1;
        put_rdy_i[1] = 1'b0;
      end
    join
    chk("full_put_delay", last_ack_cyc - rc, 2);
    chk("full_put_wait", w, 5);
    chk("get_dat_hold", fsl_dat_o, 32'hA5A5A5A5);
    put_rdy_i[1] = 1'b1;
    repeat (4) @(posedge gclk);
    #1;
    put_rdy_i[1] = 1'b0;
    chk("drain_empty", put_vld_o[1], 0);

    // Simultaneous pop and push on a two-entry PUT FIFO.
    core_xfer(1'b1, 1'b1, 32'h11, 0, w);
    core_xfer(1'b1, 1'b1, 32'h22, 0, w);
    put_rdy_i[1] = 1'b1;
    fork
      core_xfer(1'b1, 1'b1, 32'h33, 0, w);
      begin
        @(posedge gclk); #1;
        put_rdy_i[1] = 1'b0;
      end
    join
    chk("simul_latency", w, 1);
    put_rdy_i[1] = 1'b1;
    @(posedge gclk); #1;
    chk("simul_count_1left", put_vld_o[1], 1);
    @(posedge gclk); #1;
    put_rdy_i[1] = 1'b0;
    chk("simul_count_0left", put_vld_o[1], 0);

    // Reset while a GET is being acknowledged.
    fork
      core_xfer(1'b0, 1'b1, '0, 1, w);
      begin
        repeat (3) @(posedge gclk);
        #1;
        acc_get(1, 32'hCAFEF00D, pc);
      end
    join
    get_vld_i = '0;
    put_rdy_i = '0;
    repeat (2) @(posedge gclk);
    #1;
    grst_n = 1'b1;
    @(posedge gclk); #1;
    chk("post_rst_put_vld", put_vld_o, 0);
    chk("post_rst_get_rdy", get_rdy_o, 2'b11);
    chk("post_rst_dat", fsl_dat_o, 0);
    core_xfer(1'b1, 1'b0, 32'h77, 0, w);
    put_rdy_i[0] = 1'b1;
    @(posedge gclk); #1;
    put_rdy_i[0] = 1'b0;
    chk("post_rst_drain", put_vld_o[0], 0);

    // Randomised traffic on both sides.
    done = 1'b0;
    fork
      begin
        int wr;
        for (int i = 0; i < 150; i++)
          core_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(), 0, wr);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge gclk); #1;
          put_rdy_i = 2'($urandom_range(0, 3));
          get_vld_i = 2'($urandom_range(0, 3));
          get_dat_i = {$urandom(), $urandom()};
        end
      end
    join
    put_rdy_i = '0;
    get_vld_i = '0;
    repeat (3) @(posedge gclk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
